// File: rtl/video_timing_gen.sv
// video_timing_gen
//   Runtime-reprogrammable raster timing generator. Free-running horizontal and
//   vertical counters advance on each pixel enable and are decoded into
//   registered sync/active-video/coordinate/start pulses (one-cycle latency).
//   New timing arrives over a valid/ready port, is validated, held in a shadow
//   set and swapped into the active set only on the last pixel of a frame, so
//   every frame is produced with a single consistent timing.
//
// Optional build macro:
//   VIDEO_TIMING_FRAME_CNT_EN  adds frame_cnt, a 16-bit frame counter that
//                              steps together with sof.
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   ce                  pixel enable; counters and outputs advance only when 1
//   cfg_valid/ready     config handshake; transfer when both are 1
//   cfg_h_* / cfg_v_*   offered horizontal / vertical timing (vis, fp, sync, bp)
//   cfg_err             one-cycle pulse when an offered config is rejected
//   hsync, vsync        syncs, active level set by HSYNC_POL / VSYNC_POL
//   de                  active video
//   x, y                coordinates of the pixel currently presented
//   sof, sol            start-of-frame / start-of-line pulses
//   frame_cnt           (optional) frame counter
module video_timing_gen #(
    parameter int WIDTH         = 11,
    parameter int H_VISIBLE     = 800,
    parameter int H_FRONT_PORCH = 210,
    parameter int H_SYNC        = 30,
    parameter int H_BACK_PORCH  = 16,
    parameter int V_VISIBLE     = 480,
    parameter int V_FRONT_PORCH = 22,
    parameter int V_SYNC        = 13,
    parameter int V_BACK_PORCH  = 10,
    parameter int HSYNC_POL     = 0,
    parameter int VSYNC_POL     = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ce,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [WIDTH-1:0] cfg_h_vis,
    input  logic [WIDTH-1:0] cfg_h_fp,
    input  logic [WIDTH-1:0] cfg_h_sync,
    input  logic [WIDTH-1:0] cfg_h_bp,
    input  logic [WIDTH-1:0] cfg_v_vis,
    input  logic [WIDTH-1:0] cfg_v_fp,
    input  logic [WIDTH-1:0] cfg_v_sync,
    input  logic [WIDTH-1:0] cfg_v_bp,
    output logic             cfg_err,
    output logic             hsync,
    output logic             vsync,
    output logic             de,
    output logic [WIDTH-1:0] x,
    output logic [WIDTH-1:0] y,
    output logic             sof,
    output logic             sol
`ifdef VIDEO_TIMING_FRAME_CNT_EN
    ,
    output logic [15:0]      frame_cnt
`endif
);

    typedef struct packed {
        logic [WIDTH-1:0] h_vis;
        logic [WIDTH-1:0] h_fp;
        logic [WIDTH-1:0] h_sync;
        logic [WIDTH-1:0] h_bp;
        logic [WIDTH-1:0] v_vis;
        logic [WIDTH-1:0] v_fp;
        logic [WIDTH-1:0] v_sync;
        logic [WIDTH-1:0] v_bp;
    } timing_t;

    typedef enum logic {
        CFG_IDLE,
        CFG_PENDING
    } cfg_state_e;

    localparam timing_t DEFAULT_TIMING = '{
        h_vis:  WIDTH'(H_VISIBLE),
        h_fp:   WIDTH'(H_FRONT_PORCH),
        h_sync: WIDTH'(H_SYNC),
        h_bp:   WIDTH'(H_BACK_PORCH),
        v_vis:  WIDTH'(V_VISIBLE),
        v_fp:   WIDTH'(V_FRONT_PORCH),
        v_sync: WIDTH'(V_SYNC),
        v_bp:   WIDTH'(V_BACK_PORCH)
    };

    // Largest legal total: the counters span exactly 0 .. 2^WIDTH-1.
    localparam logic [WIDTH+1:0] TOT_LIMIT = {2'b01, {WIDTH{1'b0}}};
    localparam logic [WIDTH+1:0] ONE_W     = {{(WIDTH+1){1'b0}}, 1'b1};
    localparam logic             HS_ACT    = (HSYNC_POL != 0);
    localparam logic             VS_ACT    = (VSYNC_POL != 0);

    function automatic logic [WIDTH+1:0] ext(input logic [WIDTH-1:0] v);
        return {2'b00, v};
    endfunction

    // Timing sets and handshake state
    timing_t          act_q;      // timing in force for the current frame
    timing_t          shadow_q;   // accepted config awaiting the frame wrap
    timing_t          cfg_in;
    cfg_state_e       cfg_state_q;
    logic             cfg_ready_q;
    logic             cfg_err_q;

    // Counters and registered outputs
    logic [WIDTH-1:0] hc_q, hc_d;
    logic [WIDTH-1:0] vc_q, vc_d;
    logic             hsync_q, vsync_q, de_q, sof_q, sol_q;
    logic [WIDTH-1:0] x_q, y_q;

    // Decode helpers
    logic [WIDTH+1:0] h_tot, v_tot;
    logic [WIDTH+1:0] hs_start, hs_stop, vs_start, vs_stop;
    logic [WIDTH+1:0] cfg_h_tot, cfg_v_tot;
    logic             h_end, v_end, frame_wrap;
    logic             in_hs, in_vs, de_d, sof_d, sol_d;
    logic             cfg_bad;

    always_comb begin
        cfg_in = '{
            h_vis:  cfg_h_vis,
            h_fp:   cfg_h_fp,
            h_sync: cfg_h_sync,
            h_bp:   cfg_h_bp,
            v_vis:  cfg_v_vis,
            v_fp:   cfg_v_fp,
            v_sync: cfg_v_sync,
            v_bp:   cfg_v_bp
        };

        cfg_h_tot = ext(cfg_h_vis) + ext(cfg_h_fp) + ext(cfg_h_sync) + ext(cfg_h_bp);
        cfg_v_tot = ext(cfg_v_vis) + ext(cfg_v_fp) + ext(cfg_v_sync) + ext(cfg_v_bp);
        cfg_bad   = (cfg_h_vis == '0) || (cfg_h_sync == '0) ||
                    (cfg_v_vis == '0) || (cfg_v_sync == '0) ||
                    (cfg_h_tot > TOT_LIMIT) || (cfg_v_tot > TOT_LIMIT);
    end

    always_comb begin
        h_tot    = ext(act_q.h_vis) + ext(act_q.h_fp) + ext(act_q.h_sync) + ext(act_q.h_bp);
        v_tot    = ext(act_q.v_vis) + ext(act_q.v_fp) + ext(act_q.v_sync) + ext(act_q.v_bp);
        hs_start = ext(act_q.h_vis) + ext(act_q.h_fp);
        hs_stop  = hs_start + ext(act_q.h_sync);
        vs_start = ext(act_q.v_vis) + ext(act_q.v_fp);
        vs_stop  = vs_start + ext(act_q.v_sync);

        h_end      = (ext(hc_q) == h_tot - ONE_W);
        v_end      = (ext(vc_q) == v_tot - ONE_W);
        frame_wrap = ce && h_end && v_end;

        in_hs = (ext(hc_q) >= hs_start) && (ext(hc_q) < hs_stop);
        in_vs = (ext(vc_q) >= vs_start) && (ext(vc_q) < vs_stop);
        de_d  = (hc_q < act_q.h_vis) && (vc_q < act_q.v_vis);
        sol_d = (hc_q == '0);
        sof_d = (hc_q == '0) && (vc_q == '0);

        hc_d = hc_q;
        vc_d = vc_q;
        if (ce) begin
            if (h_end) begin
                hc_d = '0;
                vc_d = v_end ? '0 : vc_q + 1'b1;
            end else begin
                hc_d = hc_q + 1'b1;
            end
        end
    end

    // Config handshake: ready is simply "no config pending", registered with
    // the state so it drops the cycle after capture and rises the cycle after
    // the frame-boundary swap.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cfg_state_q <= CFG_IDLE;
            cfg_ready_q <= 1'b1;
            cfg_err_q   <= 1'b0;
            act_q       <= DEFAULT_TIMING;
            shadow_q    <= DEFAULT_TIMING;
        end else begin
            cfg_err_q <= 1'b0;
            case (cfg_state_q)
                CFG_IDLE: begin
                    if (cfg_valid) begin
                        if (cfg_bad) begin
                            cfg_err_q <= 1'b1;
                        end else begin
                            shadow_q    <= cfg_in;
                            cfg_state_q <= CFG_PENDING;
                            cfg_ready_q <= 1'b0;
                        end
                    end
                end
                CFG_PENDING: begin
                    if (frame_wrap) begin
                        act_q       <= shadow_q;
                        cfg_state_q <= CFG_IDLE;
                        cfg_ready_q <= 1'b1;
                    end
                end
                default: begin
                    cfg_state_q <= CFG_IDLE;
                    cfg_ready_q <= 1'b1;
                end
            endcase
        end
    end

    // Outputs present the decode of the counter value before it advances.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hc_q    <= '0;
            vc_q    <= '0;
            hsync_q <= ~HS_ACT;
            vsync_q <= ~VS_ACT;
            de_q    <= 1'b0;
            x_q     <= '0;
            y_q     <= '0;
            sof_q   <= 1'b0;
            sol_q   <= 1'b0;
        end else begin
            hc_q <= hc_d;
            vc_q <= vc_d;
            if (ce) begin
                hsync_q <= in_hs ? HS_ACT : ~HS_ACT;
                vsync_q <= in_vs ? VS_ACT : ~VS_ACT;
                de_q    <= de_d;
                x_q     <= hc_q;
                y_q     <= vc_q;
                sof_q   <= sof_d;
                sol_q   <= sol_d;
            end else begin
                sof_q <= 1'b0;
                sol_q <= 1'b0;
            end
        end
    end

`ifdef VIDEO_TIMING_FRAME_CNT_EN
    logic [15:0] frame_cnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            frame_cnt_q <= '0;
        end else if (ce && sof_d) begin
            frame_cnt_q <= frame_cnt_q + 16'd1;
        end
    end

    assign frame_cnt = frame_cnt_q;
`endif

    assign cfg_ready = cfg_ready_q;
    assign cfg_err   = cfg_err_q;
    assign hsync     = hsync_q;
    assign vsync     = vsync_q;
    assign de        = de_q;
    assign x         = x_q;
    assign y         = y_q;
    assign sof       = sof_q;
    assign sol       = sol_q;

endmodule

// File: tb/tb_video_timing_gen.sv
// Testbench for video_timing_gen. Two small-default instances (sync polarity
// low and high) are checked every cycle against a pixel-tick model; a third
// instance with the full power-up defaults is checked with literal values.
module tb_video_timing_gen;

    localparam int W = 11;
    // Small power-up timing for the modelled instances: H_TOT 12, V_TOT 8.
    localparam int D_HV = 6, D_HF = 2, D_HS = 2, D_HB = 2;
    localparam int D_VV = 4, D_VF = 1, D_VS = 1, D_VB = 2;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         ce = 1'b0;
    logic         cfg_valid = 1'b0;
    logic [W-1:0] c_hv = '0, c_hf = '0, c_hs = '0, c_hb = '0;
    logic [W-1:0] c_vv = '0, c_vf = '0, c_vs = '0, c_vb = '0;
    logic [W-1:0] zero_w = '0;
    logic         zero_b = 1'b0;

    logic         rdy0, err0, hs0, vs0, de0, sof0, sol0;
    logic         rdy1, err1, hs1, vs1, de1, sof1, sol1;
    logic         rdyd, errd, hsd, vsd, ded, sofd, sold;
    logic [W-1:0] x0, y0, x1, y1, xd, yd;
`ifdef VIDEO_TIMING_FRAME_CNT_EN
    logic [15:0]  fc0, fc1, fcd;
`endif

    int checks = 0;
    int errors = 0;
    bit toggle_ce = 1'b0;

    always #5 clk = ~clk;

    video_timing_gen #(
        .WIDTH(W), .H_VISIBLE(D_HV), .H_FRONT_PORCH(D_HF), .H_SYNC(D_HS), .H_BACK_PORCH(D_HB),
        .V_VISIBLE(D_VV), .V_FRONT_PORCH(D_VF), .V_SYNC(D_VS), .V_BACK_PORCH(D_VB),
        .HSYNC_POL(0), .VSYNC_POL(0)
    ) dut0 (
        .clk(clk), .rst_n(rst_n), .ce(ce), .cfg_valid(cfg_valid), .cfg_ready(rdy0),
        .cfg_h_vis(c_hv), .cfg_h_fp(c_hf), .cfg_h_sync(c_hs), .cfg_h_bp(c_hb),
        .cfg_v_vis(c_vv), .cfg_v_fp(c_vf), .cfg_v_sync(c_vs), .cfg_v_bp(c_vb),
        .cfg_err(err0), .hsync(hs0), .vsync(vs0), .de(de0), .x(x0), .y(y0),
        .sof(sof0), .sol(sol0)
`ifdef VIDEO_TIMING_FRAME_CNT_EN
        , .frame_cnt(fc0)
`endif
    );

    video_timing_gen #(
        .WIDTH(W), .H_VISIBLE(D_HV), .H_FRONT_PORCH(D_HF), .H_SYNC(D_HS), .H_BACK_PORCH(D_HB),
        .V_VISIBLE(D_VV), .V_FRONT_PORCH(D_VF), .V_SYNC(D_VS), .V_BACK_PORCH(D_VB),
        .HSYNC_POL(1), .VSYNC_POL(1)
    ) dut1 (
        .clk(clk), .rst_n(rst_n), .ce(ce), .cfg_valid(cfg_valid), .cfg_ready(rdy1),
        .cfg_h_vis(c_hv), .cfg_h_fp(c_hf), .cfg_h_sync(c_hs), .cfg_h_bp(c_hb),
        .cfg_v_vis(c_vv), .cfg_v_fp(c_vf), .cfg_v_sync(c_vs), .cfg_v_bp(c_vb),
        .cfg_err(err1), .hsync(hs1), .vsync(vs1), .de(de1), .x(x1), .y(y1),
        .sof(sof1), .sol(sol1)
`ifdef VIDEO_TIMING_FRAME_CNT_EN
        , .frame_cnt(fc1)
`endif
    );

    video_timing_gen #(.WIDTH(W)) dutd (
        .clk(clk), .rst_n(rst_n), .ce(ce), .cfg_valid(zero_b), .cfg_ready(rdyd),
        .cfg_h_vis(zero_w), .cfg_h_fp(zero_w), .cfg_h_sync(zero_w), .cfg_h_bp(zero_w),
        .cfg_v_vis(zero_w), .cfg_v_fp(zero_w), .cfg_v_sync(zero_w), .cfg_v_bp(zero_w),
        .cfg_err(errd), .hsync(hsd), .vsync(vsd), .de(ded), .x(xd), .y(yd),
        .sof(sofd), .sol(sold)
`ifdef VIDEO_TIMING_FRAME_CNT_EN
        , .frame_cnt(fcd)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // The frame is a sequence of pixel ticks; a tick's coordinates are
    // tick % H_TOT and tick / H_TOT, and each output is a range test on them.
    int   ma[8];
    int   mp[8];
    int   c[8];
    bit   mpend, old_pend, model_on = 1'b0;
    int   mtick, ht, vt, hc, vc;
    bit   m_hs, m_vs, m_de, m_sof, m_sol, m_err, m_ready;
    int   m_x, m_y;
    logic [15:0] m_fc;

    always @(posedge clk) begin
        if (!rst_n) begin
            ma = '{D_HV, D_HF, D_HS, D_HB, D_VV, D_VF, D_VS, D_VB};
            mpend = 0; mtick = 0;
            m_hs = 0; m_vs = 0; m_de = 0; m_x = 0; m_y = 0;
            m_sof = 0; m_sol = 0; m_err = 0; m_ready = 1; m_fc = '0;
            model_on = 1;
        end else if (model_on) begin
            old_pend = mpend;
            m_err = 0;
            if (cfg_valid && !old_pend) begin
                c = '{int'(c_hv), int'(c_hf), int'(c_hs), int'(c_hb),
                      int'(c_vv), int'(c_vf), int'(c_vs), int'(c_vb)};
                if (c[0] == 0 || c[2] == 0 || c[4] == 0 || c[6] == 0 ||
                    c[0] + c[1] + c[2] + c[3] > 2048 || c[4] + c[5] + c[6] + c[7] > 2048)
                    m_err = 1;
                else begin
                    mp = c;
                    mpend = 1;
                end
            end
            if (ce) begin
                ht = ma[0] + ma[1] + ma[2] + ma[3];
                vt = ma[4] + ma[5] + ma[6] + ma[7];
                hc = mtick % ht;
                vc = mtick / ht;
                m_hs  = (hc >= ma[0] + ma[1]) && (hc < ma[0] + ma[1] + ma[2]);
                m_vs  = (vc >= ma[4] + ma[5]) && (vc < ma[4] + ma[5] + ma[6]);
                m_de  = (hc < ma[0]) && (vc < ma[4]);
                m_x   = hc;
                m_y   = vc;
                m_sof = (mtick == 0);
                m_sol = (hc == 0);
                if (m_sof) m_fc = m_fc + 16'd1;
                mtick++;
                if (mtick == ht * vt) begin
                    mtick = 0;
                    if (old_pend) begin
                        ma = mp;
                        mpend = 0;
                    end
                end
            end else begin
                m_sof = 0;
                m_sol = 0;
            end
            m_ready = !mpend;
        end
    end

    always @(negedge clk) begin
        if (model_on) begin
            check("hsync", hs0, m_hs ? 0 : 1);
            check("hsync_pol1", hs1, m_hs ? 1 : 0);
            check("vsync", vs0, m_vs ? 0 : 1);
            check("vsync_pol1", vs1, m_vs ? 1 : 0);
            check("de", de0, m_de);
            check("de_pol1", de1, m_de);
            check("x", x0, m_x);
            check("x_pol1", x1, m_x);
            check("y", y0, m_y);
            check("y_pol1", y1, m_y);
            check("sof", sof0, m_sof);
            check("sof_pol1", sof1, m_sof);
            check("sol", sol0, m_sol);
            check("sol_pol1", sol1, m_sol);
            check("cfg_ready", rdy0, m_ready);
            check("cfg_ready_pol1", rdy1, m_ready);
            check("cfg_err", err0, m_err);
            check("cfg_err_pol1", err1, m_err);
`ifdef VIDEO_TIMING_FRAME_CNT_EN
            check("frame_cnt", fc0, m_fc);
            check("frame_cnt_pol1", fc1, m_fc);
`endif
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic step();
        @(negedge clk);
        if (toggle_ce) ce = ~ce;
    endtask

    task automatic offer(input int hv, hf, hs, hb, vv, vf, vs, vb);
        c_hv = W'(hv); c_hf = W'(hf); c_hs = W'(hs); c_hb = W'(hb);
        c_vv = W'(vv); c_vf = W'(vf); c_vs = W'(vs); c_vb = W'(vb);
        cfg_valid = 1'b1;
        step();
        cfg_valid = 1'b0;
    endtask

    task automatic wait_sof(input string name, input int max, output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (!sof0 && n < max);
        check({name, "_sof_seen"}, sof0, 1);
    endtask

    // Called at a sof cycle; walks one frame and tallies dut0/dut1 outputs.
    task automatic measure(output int n, output int de_c, output int hs_c,
                           output int vs_c, output int hs1_c);
        n = 0; de_c = 0; hs_c = 0; vs_c = 0; hs1_c = 0;
        do begin
            if (ce || toggle_ce) begin
                de_c  += int'(de0);
                hs_c  += int'(!hs0);
                vs_c  += int'(!vs0);
                hs1_c += int'(hs1);
            end
            step();
            n++;
        end while (!sof0 && n < 2000);
    endtask

    int n, dc, hc_cnt, vc_cnt, h1c;

    initial begin
        // Reset state
        repeat (2) step();
        check("rst_ready", rdy0, 1);
        check("rst_de", de0, 0);
        check("rst_hsync", hs0, 1);
        check("rst_hsync_pol1", hs1, 0);
        check("rst_sof", sof0, 0);
        rst_n = 1'b1;
        ce = 1'b1;
        step();
        check("first_sof", sof0, 1);
        check("first_sol", sol0, 1);
        check("first_de", de0, 1);
        check("first_xy", {x0, y0}, 0);

        // 1: load 4/1/2/1 x 3/1/1/1, apply at the default frame end
        offer(4, 1, 2, 1, 3, 1, 1, 1);
        check("s1_ready_low", rdy0, 0);
        wait_sof("s1_apply", 300, n);
        check("s1_ready_back", rdy0, 1);
        measure(n, dc, hc_cnt, vc_cnt, h1c);
        check("s1_period", n, 48);
        check("s1_de_count", dc, 12);
        check("s1_hsync_count", hc_cnt, 12);
        check("s1_vsync_count", vc_cnt, 8);
        check("s6_hsync_pol1_count", h1c, 12);

        // 2: ce toggling doubles the period
        toggle_ce = 1'b1;
        wait_sof("s2_align", 300, n);
        measure(n, dc, hc_cnt, vc_cnt, h1c);
        check("s2_period", n, 96);
        toggle_ce = 1'b0;
        ce = 1'b1;

        // 3: rejected config (h_sync = 0)
        offer(4, 1, 0, 1, 3, 1, 1, 1);
        check("s3_err_pulse", err0, 1);
        check("s3_ready_high", rdy0, 1);
        step();
        check("s3_err_clear", err0, 0);
        wait_sof("s3_align", 300, n);
        measure(n, dc, hc_cnt, vc_cnt, h1c);
        check("s3_period_kept", n, 48);

        // 4: valid config offered at y=2, x=0 (tick 16 of 48)
        n = 0;
        while (!(y0 == 2 && x0 == 0) && n < 100) begin
            step();
            n++;
        end
        check("s4_reach_y2", y0, 2);
        offer(3, 1, 1, 1, 2, 1, 1, 1);
        check("s4_ready_low", rdy0, 0);
        wait_sof("s4_apply", 300, n);
        check("s4_old_frame_rest", n + 1, 32);
        measure(n, dc, hc_cnt, vc_cnt, h1c);
        check("s4_new_period", n, 30);
        check("s4_de_count", dc, 6);
        check("s4_hsync_count", hc_cnt, 5);
        check("s4_vsync_count", vc_cnt, 6);

        // 5: reset mid-line with a config pending
        offer(4, 1, 2, 1, 3, 1, 1, 1);
        repeat (3) step();
        rst_n = 1'b0;
        step();
        check("s5_ready", rdy0, 1);
        check("s5_de", de0, 0);
        check("s5_xy", {x0, y0}, 0);
        check("s5_sof_sol", {sof0, sol0}, 0);
        check("s5_syncs", {hs0, vs0, hs1, vs1}, 4'b1100);
        check("s5_def_syncs", {hsd, vsd, ded}, 3'b110);
        rst_n = 1'b1;
        step();
        check("s5_first_sof", sof0, 1);
        measure(n, dc, hc_cnt, vc_cnt, h1c);
        check("s5_default_period", n, 96);
        check("s5_default_de", dc, 24);

        // Full-size power-up defaults on dutd: hsync at x=1010, line 1056
        n = 0;
        while (hsd && n < 3000) begin
            step();
            n++;
        end
        check("def_hsync_start_x", xd, 1010);
        check("def_de_in_blank", ded, 0);
        n = 0;
        while (!sold && n < 3000) begin
            step();
            n++;
        end
        check("def_sol_seen", sold, 1);
        n = 0;
        do begin
            step();
            n++;
        end while (!sold && n < 3000);
        check("def_line_length", n, 1056);
        check("def_line_y", yd, 2);

        repeat (3) step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/video_timing_gen.md
Name: video_timing_gen

Overview:
Parametrised, runtime-reprogrammable successor to the fixed-mode VGA/LCD sync generator. Produces registered hsync/vsync/de, pixel coordinates, and start-of-frame/line pulses for the display pipeline feeding the DTBDM de-noise output path. Timing is loaded through a valid/ready config port and takes effect only at a frame boundary. A pixel clock-enable allows running from the system clock.

Parameters:
WIDTH, 11, bit width of counters, coordinates and config fields
H_VISIBLE, 800, power-up horizontal active pixels
H_FRONT_PORCH, 210, power-up horizontal front porch
H_SYNC, 30, power-up horizontal sync width
H_BACK_PORCH, 16, power-up horizontal back porch
V_VISIBLE, 480, power-up vertical active lines
V_FRONT_PORCH, 22, power-up vertical front porch
V_SYNC, 13, power-up vertical sync width
V_BACK_PORCH, 10, power-up vertical back porch
HSYNC_POL, 0, hsync active level (0 = active-low)
VSYNC_POL, 0, vsync active level (0 = active-low)

Ports:
clk  in  1  clock
rst_n  in  1  reset, synchronous, active-low
ce  in  1  pixel enable; counters advance only when 1
cfg_valid  in  1  new timing offered
cfg_ready  out  1  block can accept timing
cfg_h_vis, cfg_h_fp, cfg_h_sync, cfg_h_bp  in  WIDTH each  horizontal timing
cfg_v_vis, cfg_v_fp, cfg_v_sync, cfg_v_bp  in  WIDTH each  vertical timing
cfg_err  out  1  one-cycle pulse: offered config rejected
hsync  out  1  horizontal sync, polarity per HSYNC_POL
vsync  out  1  vertical sync, polarity per VSYNC_POL
de  out  1  active video (visible h and visible v)
x  out  WIDTH  hcount of current pixel
y  out  WIDTH  vcount of current pixel
sof  out  1  pulse at pixel (0,0)
sol  out  1  pulse at hcount 0 of every line

Behaviour:
- Active timing set A (8 fields) resets to parameter defaults. H_TOT = sum of 4 h fields, V_TOT = sum of 4 v fields, both computed at WIDTH+2 bits.
- Counters: hcount 0..H_TOT-1, vcount 0..V_TOT-1. On ce=1: hcount increments. At hcount=H_TOT-1, hcount wraps to 0 and vcount increments. At vcount=V_TOT-1 (on that same line-end), vcount wraps to 0. On ce=0: counters hold.
- Decode, using counter value c:
  - hsync asserted for H_VIS+H_FP <= hc < H_VIS+H_FP+H_SYNC; vsync likewise with the v fields.
  - de = (hc < H_VIS) & (vc < V_VIS).
  - sol = (hc == 0); sof = (hc == 0) & (vc == 0).
- Outputs are registered, latency 1. On a ce=1 cycle, outputs take the decode of the pre-increment counter. On ce=0, hsync/vsync/de/x/y hold and sof/sol are driven 0.
- Reset values: counters 0, hsync=~HSYNC_POL, vsync=~VSYNC_POL, de=0, x=0, y=0, sof=0, sol=0, cfg_ready=1, cfg_err=0, pending=0. The first ce=1 after reset gives de=1, sof=1, sol=1, x=0, y=0.
- Config handshake:
  - Transfer occurs when cfg_valid & cfg_ready.
  - If any of vis/sync fields = 0, or H_TOT or V_TOT > 2^WIDTH: pulse cfg_err the next cycle. The config is discarded and cfg_ready stays 1.
  - Otherwise the fields are captured into shadow register P, pending=1, and cfg_ready=0 from the next cycle.
- Apply: on the ce=1 cycle where hc=H_TOT-1 and vc=V_TOT-1 with pending=1, A<=P, pending<=0, counters wrap to 0. cfg_ready returns to 1 the following cycle. The first frame under the new timing starts with sof.
- cfg_valid while cfg_ready=0 is ignored (no capture, no error). Porch fields of 0 are legal.
- Reset mid-frame or with a pending config: pending is dropped and A returns to the defaults.

Optional Feature:
VIDEO_TIMING_FRAME_CNT_EN:
- Defined: adds output frame_cnt (16 bits), reset 0. It increments (wrapping 0xFFFF->0) on every frame wrap, registered alongside sof, so it changes in the same cycle sof=1.
- Undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
1. Reset, then load H=4/1/2/1 and V=3/1/1/1, ce=1 constant, run past one frame -> after apply, sof every 48 cycles and hsync low at x=5,6 each line. de=1 for 12 cycles per frame; vsync low only on line y=4.
2. Same timing, ce toggling 1,0 -> period doubles to 96 clocks. sof/sol are high only on ce=1 cycles; x/y hold on ce=0.
3. Offer cfg_h_sync=0 -> cfg_err=1 for exactly one cycle; cfg_ready stays 1 and timing is unchanged.
4. Offer a valid config mid-frame at y=2 -> cfg_ready=0 until the frame wrap. New timing starts exactly at the next sof; the old frame completes unchanged.
5. Assert rst_n=0 for one cycle mid-line with a config pending -> outputs return to reset values and defaults resume (H_TOT=1056, V_TOT=525). cfg_ready=1.
6. HSYNC_POL=1, VSYNC_POL=1 instance -> syncs idle 0 and pulse high over the same counts as scenario 1.
